// File: rtl/clk_pkg.sv
// Shared encodings and field helpers for the digital-clock time-setting path.
package clk_pkg;

    localparam int unsigned TIME_W = 6;

    localparam logic [TIME_W-1:0] HRS_MAX = 6'd23;
    localparam logic [TIME_W-1:0] MIN_MAX = 6'd59;

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        SET_HRS = 2'b01,
        SET_MIN = 2'b10
    } mode_t;

    // One step up or down with wrap at [0, max]; an out-of-range value steps to a legal one.
    function automatic logic [TIME_W-1:0] wrap_step(
        input logic [TIME_W-1:0] val,
        input logic [TIME_W-1:0] max,
        input logic              inc
    );
        if (inc) begin
            return (val >= max) ? '0 : val + 1'b1;
        end
        return (val == '0 || val > max) ? max : val - 1'b1;
    endfunction

    function automatic logic [TIME_W-1:0] capture(
        input logic [TIME_W-1:0] val,
        input logic [TIME_W-1:0] max
    );
        return (val > max) ? '0 : val;
    endfunction

endpackage

// File: rtl/pb_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stable-level debounce,
// rising-edge press pulse and hold-to-repeat pulse.
module pb_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned REPEAT_DELAY    = 50_000_000,
    parameter int unsigned REPEAT_RATE     = 20_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    input  logic rpt_clr,
    output logic press,
    output logic rpt
);

    logic        sync1;
    logic        sync2;
    logic        level;
    logic        level_d;
    logic        rpt_phase;
    logic [31:0] db_cnt;
    logic [31:0] rpt_cnt;
    logic [31:0] rpt_limit;

    assign rpt_limit = rpt_phase ? 32'(REPEAT_RATE - 1) : 32'(REPEAT_DELAY - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            level     <= 1'b0;
            level_d   <= 1'b0;
            press     <= 1'b0;
            rpt       <= 1'b0;
            rpt_phase <= 1'b0;
            db_cnt    <= '0;
            rpt_cnt   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;

            if (sync2 != level) begin
                if (db_cnt >= 32'(DEBOUNCE_CYCLES - 1)) begin
                    level  <= sync2;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + 32'd1;
                end
            end else begin
                db_cnt <= '0;
            end

            level_d <= level;
            press   <= level & ~level_d;

            // The timer restarts on the press edge so the first repeat lands REPEAT_DELAY after it.
            rpt <= 1'b0;
            if (!level || !level_d || rpt_clr) begin
                rpt_cnt   <= '0;
                rpt_phase <= 1'b0;
            end else if (rpt_cnt >= rpt_limit) begin
                rpt       <= 1'b1;
                rpt_cnt   <= '0;
                rpt_phase <= 1'b1;
            end else begin
                rpt_cnt <= rpt_cnt + 32'd1;
            end
        end
    end

endmodule

// File: rtl/time_set_ctrl.sv
// Time-setting front end: RUN / SET_HRS / SET_MIN editor with commit pulse and field blink.
// Optional SET_TIMEOUT_EN builds an idle timer that abandons set mode.
module time_set_ctrl
    import clk_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned REPEAT_DELAY    = 50_000_000,
    parameter int unsigned REPEAT_RATE     = 20_000_000,
    parameter int unsigned BLINK_HALF      = 25_000_000
`ifdef SET_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES  = 1_000_000_000
`endif
) (
    input  logic              clk_100MHz,
    input  logic              reset_pb,
    input  logic              mode_pb,
    input  logic              up_pb,
    input  logic              down_pb,
    input  logic [TIME_W-1:0] cur_hrs,
    input  logic [TIME_W-1:0] cur_min,
    output logic [TIME_W-1:0] set_hrs,
    output logic [TIME_W-1:0] set_min,
    output logic              time_load,
    output logic              set_active,
    output logic              blank_hrs,
    output logic              blank_min,
    output logic [1:0]        mode_state
);

    mode_t       state;
    logic [31:0] blink_cnt;

    logic mode_press;
    logic up_press;
    logic up_rpt;
    logic dn_press;
    logic dn_rpt;
    logic up_evt;
    logic dn_evt;
    logic up_only;
    logic dn_only;
    logic both_evt;

    pb_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_RATE    (REPEAT_RATE)
    ) u_mode (
        .clk    (clk_100MHz),
        .rst    (reset_pb),
        .raw    (mode_pb),
        .rpt_clr(1'b0),
        .press  (mode_press),
        .rpt    ()
    );

    pb_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_RATE    (REPEAT_RATE)
    ) u_up (
        .clk    (clk_100MHz),
        .rst    (reset_pb),
        .raw    (up_pb),
        .rpt_clr(both_evt),
        .press  (up_press),
        .rpt    (up_rpt)
    );

    pb_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_RATE    (REPEAT_RATE)
    ) u_down (
        .clk    (clk_100MHz),
        .rst    (reset_pb),
        .raw    (down_pb),
        .rpt_clr(both_evt),
        .press  (dn_press),
        .rpt    (dn_rpt)
    );

    assign up_evt     = up_press | up_rpt;
    assign dn_evt     = dn_press | dn_rpt;
    assign both_evt   = up_evt & dn_evt;
    assign up_only    = up_evt & ~dn_evt;
    assign dn_only    = dn_evt & ~up_evt;
    assign mode_state = state;

`ifdef SET_TIMEOUT_EN
    logic [31:0] idle_cnt;
    logic        any_evt;

    assign any_evt = mode_press | up_evt | dn_evt;
`endif

    always_ff @(posedge clk_100MHz or posedge reset_pb) begin
        if (reset_pb) begin
            state      <= RUN;
            set_hrs    <= '0;
            set_min    <= '0;
            time_load  <= 1'b0;
            set_active <= 1'b0;
            blank_hrs  <= 1'b0;
            blank_min  <= 1'b0;
            blink_cnt  <= '0;
`ifdef SET_TIMEOUT_EN
            idle_cnt   <= '0;
`endif
        end else begin
            time_load <= 1'b0;

            unique case (state)
                RUN: begin
                    if (mode_press) begin
                        set_hrs    <= capture(cur_hrs, HRS_MAX);
                        set_min    <= capture(cur_min, MIN_MAX);
                        state      <= SET_HRS;
                        set_active <= 1'b1;
                        blink_cnt  <= '0;
                        blank_hrs  <= 1'b0;
                        blank_min  <= 1'b0;
                    end
                end

                SET_HRS: begin
                    if (mode_press) begin
                        state     <= SET_MIN;
                        blink_cnt <= '0;
                        blank_hrs <= 1'b0;
                        blank_min <= 1'b0;
                    end else if (up_only || dn_only) begin
                        set_hrs   <= wrap_step(set_hrs, HRS_MAX, up_only);
                        blink_cnt <= '0;
                        blank_hrs <= 1'b0;
                    end else if (blink_cnt >= 32'(BLINK_HALF - 1)) begin
                        blink_cnt <= '0;
                        blank_hrs <= ~blank_hrs;
                    end else begin
                        blink_cnt <= blink_cnt + 32'd1;
                    end
                end

                SET_MIN: begin
                    if (mode_press) begin
                        state      <= RUN;
                        time_load  <= 1'b1;
                        set_active <= 1'b0;
                        blink_cnt  <= '0;
                        blank_hrs  <= 1'b0;
                        blank_min  <= 1'b0;
                    end else if (up_only || dn_only) begin
                        set_min   <= wrap_step(set_min, MIN_MAX, up_only);
                        blink_cnt <= '0;
                        blank_min <= 1'b0;
                    end else if (blink_cnt >= 32'(BLINK_HALF - 1)) begin
                        blink_cnt <= '0;
                        blank_min <= ~blank_min;
                    end else begin
                        blink_cnt <= blink_cnt + 32'd1;
                    end
                end

                default: begin
                    state      <= RUN;
                    set_active <= 1'b0;
                    blank_hrs  <= 1'b0;
                    blank_min  <= 1'b0;
                end
            endcase

`ifdef SET_TIMEOUT_EN
            // Placed after the case so an expiry overrides the idle-cycle blink update.
            if (state == RUN || any_evt) begin
                idle_cnt <= '0;
            end else if (idle_cnt >= 32'(TIMEOUT_CYCLES - 1)) begin
                idle_cnt   <= '0;
                state      <= RUN;
                set_active <= 1'b0;
                blink_cnt  <= '0;
                blank_hrs  <= 1'b0;
                blank_min  <= 1'b0;
            end else begin
                idle_cnt <= idle_cnt + 32'd1;
            end
`endif
        end
    end

endmodule
